// File: rtl/qspi_slave_bridge.sv
// qspi_slave_bridge: QSPI (SPI mode 0) slave front end, oversampled in the clk
// domain, bridging single/quad read and write commands to a synchronous memory
// port (port A of a dual-port RAM).
// Optional feature: define QSPI_STATUS_CMD_EN to add the 0x05 sticky status read.
module qspi_slave_bridge #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 8,
  parameter int DUMMY   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              qspi_clk,
  input  logic              qspi_cs,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int          SH_W       = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [15:0] ADDR_BITS  = 16'(ADDR_W);
  localparam logic [15:0] DATA_BITS  = 16'(DATA_W);
  localparam logic [15:0] DUMMY_LAST = 16'(DUMMY - 1);
  localparam logic [2:0]  LAT        = 3'(MEM_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sclk_sync, cs_sync;
  logic [3:0]        io_meta, io_s;
  logic              sclk_d, sclk_s, cs_s, rise, fall, shifting;
  logic [SH_W-2:0]   sh_q;
  logic [SH_W-1:0]   sh_next;
  logic [15:0]       cnt_q, cnt_inc, out_cnt_q, out_inc, step;
  logic              quad_q, write_q, stat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rd_buf_q, sh_out_q, out_word, status_word;
  logic [2:0]        lat_q;
  logic [7:0]        cmd_byte;
  logic              dec_known, dec_write, dec_quad, dec_stat;
  logic              cmd_done, addr_done, word_done, dummy_done, out_last;

  // Two-flop synchronisers for the pads plus one delayed SCLK for edge detect.
  // SCLK and IO share the same latency, so IO is aligned with the detected rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      io_meta   <= 4'h0;
      io_s      <= 4'h0;
      sclk_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // the pre-edge value of its neighbours, independent of statement order.
      sclk_sync <= {sclk_sync[0], qspi_clk};
      cs_sync   <= {cs_sync[0], qspi_cs};
      io_meta   <= io_in;
      io_s      <= io_meta;
      sclk_d    <= sclk_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign busy      = ~cs_s;
  assign mem_addr  = addr_q;
  assign io_oe     = (state_q == S_RDATA) ? (quad_q ? 4'hF : 4'h2) : 4'h0;

  assign shifting   = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_WDATA);
  assign step       = quad_q ? 16'd4 : 16'd1;
  assign cnt_inc    = cnt_q + step;
  assign out_inc    = out_cnt_q + step;
  assign sh_next    = quad_q ? {sh_q[SH_W-5:0], io_s} : {sh_q, io_s[0]};
  assign cmd_byte   = {sh_q[6:0], io_s[0]};
  assign cmd_done   = rise && (state_q == S_CMD)   && (cnt_q == 16'd7);
  assign addr_done  = rise && (state_q == S_ADDR)  && (cnt_inc == ADDR_BITS);
  assign word_done  = rise && (state_q == S_WDATA) && (cnt_inc == DATA_BITS);
  assign dummy_done = rise && (state_q == S_DUMMY) && (cnt_q == DUMMY_LAST);
  assign out_last   = (out_inc == DATA_BITS);
  assign out_word   = (out_cnt_q == 16'd0) ? (stat_q ? status_word : rd_buf_q) : sh_out_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Command decode and next-state logic; CS high overrides everything.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    dec_known = 1'b1;
    dec_write = 1'b0;
    dec_quad  = 1'b0;
    dec_stat  = 1'b0;
    case (cmd_byte)
      8'h02:   dec_write = 1'b1;
      8'h32:   begin dec_write = 1'b1; dec_quad = 1'b1; end
      8'h03:   dec_quad  = 1'b0;
      8'h6B:   dec_quad  = 1'b1;
`ifdef QSPI_STATUS_CMD_EN
      8'h05:   dec_stat  = 1'b1;
`endif
      default: dec_known = 1'b0;
    endcase
    case (state_q)
      S_IDLE:  if (!cs_s) state_d = S_CMD;
      S_CMD:   if (cmd_done) state_d = !dec_known ? S_IGNORE : (dec_stat ? S_RDATA : S_ADDR);
      S_ADDR:  if (addr_done) state_d = write_q ? S_WDATA : ((DUMMY == 0) ? S_RDATA : S_DUMMY);
      S_DUMMY: if (dummy_done) state_d = S_RDATA;
      default: state_d = state_q;
    endcase
    if (cs_s) state_d = S_IDLE;
  end

  // Datapath: input shifting, address/word handling, memory strobes, read shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      out_cnt_q <= '0;
      quad_q    <= 1'b0;
      write_q   <= 1'b0;
      stat_q    <= 1'b0;
      addr_q    <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      lat_q     <= '0;
      rd_buf_q  <= '0;
      sh_out_q  <= '0;
      io_out    <= 4'h0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      // The address advances in the clk after each strobe, wrapping naturally.
      if (mem_we || mem_re) addr_q <= addr_q + ADDR_W'(1);
      if (rise && shifting) sh_q <= sh_next[SH_W-2:0];

      if (state_d != state_q)
        cnt_q <= '0;
      else if (rise && (state_q == S_DUMMY))
        cnt_q <= cnt_q + 16'd1;
      else if (rise && shifting)
        cnt_q <= word_done ? '0 : cnt_inc;

      if (state_q == S_IDLE) begin
        quad_q  <= 1'b0;
        write_q <= 1'b0;
        stat_q  <= 1'b0;
      end
      if (cmd_done) begin
        quad_q  <= dec_quad;
        write_q <= dec_write;
        stat_q  <= dec_stat;
      end
      if (addr_done) begin
        addr_q <= sh_next[ADDR_W-1:0];
        mem_re <= !write_q;
      end
      // A word completing in the same sample as CS rising is still written.
      if (word_done) begin
        mem_wdata <= sh_next[DATA_W-1:0];
        mem_we    <= 1'b1;
      end

      if (mem_re)            lat_q <= LAT;
      else if (lat_q != 3'd0) lat_q <= lat_q - 3'd1;
      if (lat_q == 3'd1)     rd_buf_q <= mem_rdata;

      // Each word start loads the prefetched data and requests the next word.
      if (state_q != S_RDATA) begin
        out_cnt_q <= '0;
        io_out    <= 4'h0;
      end else if (fall) begin
        io_out    <= quad_q ? out_word[DATA_W-1 -: 4] : {2'b00, out_word[DATA_W-1], 1'b0};
        sh_out_q  <= quad_q ? (out_word << 4) : (out_word << 1);
        out_cnt_q <= out_last ? '0 : out_inc;
        if ((out_cnt_q == 16'd0) && !stat_q) mem_re <= 1'b1;
      end
    end
  end

`ifdef QSPI_STATUS_CMD_EN
  logic sticky_abort, sticky_badcmd;

  assign status_word = {sticky_abort, sticky_badcmd, {(DATA_W-2){1'b0}}};

  // Sticky error flags, cleared once a full status word has been shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_abort  <= 1'b0;
      sticky_badcmd <= 1'b0;
    end else begin
      if (stat_q && (state_q == S_RDATA) && fall && out_last) begin
        sticky_abort  <= 1'b0;
        sticky_badcmd <= 1'b0;
      end
      if ((state_q == S_WDATA) && cs_s && !word_done && ((cnt_q != 16'd0) || rise))
        sticky_abort <= 1'b1;
      if (cmd_done && !dec_known)
        sticky_badcmd <= 1'b1;
    end
  end
`else
  assign status_word = '0;
`endif

endmodule

// File: tb/tb_qspi_slave_bridge.sv
// tb_qspi_slave_bridge: drives QSPI frames as a bus master and compares write
// strobes, read data and output enables with a transaction-level memory model.
module tb_qspi_slave_bridge;
  localparam int HALF = 6;   // clk cycles per SCLK half period
  localparam int NDUM = 4;

  logic        clk = 1'b0, rst = 1'b1, qspi_clk = 1'b0, qspi_cs = 1'b1;
  logic [3:0]  io_in = 4'h0, io_out, io_oe;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata = 8'h00;
  logic        mem_we, mem_re, busy;

  int n_cmp = 0, n_bad = 0, re_cnt = 0;
  logic [31:0] wq[$];            // observed writes {addr, data}
  logic [31:0] expq[$];          // expected writes {addr, data}
  logic [7:0]  wdat[$];          // data words for the next write frame
  logic [7:0]  ram[logic [23:0]];     // RAM behind the DUT port
  logic [7:0]  ref_mem[logic [23:0]]; // reference model contents
  bit          exp_abort = 0, exp_badcmd = 0;

  qspi_slave_bridge dut (
    .clk(clk), .rst(rst), .qspi_clk(qspi_clk), .qspi_cs(qspi_cs),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // RAM responder with one clk read latency; logs every write strobe.
  always @(posedge clk) begin
    if (mem_re) begin
      re_cnt++;
      mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : dflt(mem_addr);
    end
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      ram[mem_addr] = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_unit(input bit q, input logic [3:0] v);
    logic [3:0] r;
    r = 4'($urandom);
    io_in = q ? v : {r[3:1], v[0]};
    half();
    chk("oe_idle", io_oe, 0);
    qspi_clk = 1'b1;
    half();
    qspi_clk = 1'b0;
  endtask

  task automatic recv_unit(input bit q, input logic [3:0] exp);
    half();
    io_in = 4'($urandom);
    if (q) chk("rd_nibble", io_out, exp);
    else   chk("rd_bit", io_out[1], exp[0]);
    chk("rd_oe", io_oe, q ? 4'hF : 4'h2);
    qspi_clk = 1'b1;
    half();
    qspi_clk = 1'b0;
  endtask

  task automatic send_field(input bit q, input logic [31:0] v, input int nbits);
    if (q) for (int i = nbits / 4 - 1; i >= 0; i--) send_unit(1'b1, v[4*i +: 4]);
    else   for (int i = nbits - 1; i >= 0; i--) send_unit(1'b0, {3'b000, v[i]});
  endtask

  task automatic frame_begin();
    re_cnt = 0;
    qspi_cs = 1'b0;
    half();
    chk("busy_hi", busy, 1);
  endtask

  task automatic frame_end();
    half();
    qspi_cs = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("oe_drop", io_oe, 0);
    half();
    half();
    chk("busy_lo", busy, 0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, wq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < wq.size(); i++) chk(tag, wq[i], expq[i]);
    wq.delete();
    expq.delete();
  endtask

  // Write frame consuming wdat; 'part' extra units leave a partial word behind.
  task automatic do_write(input bit q, input logic [23:0] a, input int part);
    int n;
    n = wdat.size();
    frame_begin();
    send_field(1'b0, q ? 32'h32 : 32'h02, 8);
    send_field(q, {8'h00, a}, 24);
    for (int i = 0; i < n; i++) begin
      send_field(q, {24'h0, wdat[i]}, 8);
      expq.push_back({24'(a + 24'(i)), wdat[i]});
      ref_mem[24'(a + 24'(i))] = wdat[i];
    end
    for (int i = 0; i < part; i++) send_unit(q, 4'($urandom));
    frame_end();
    wdat.delete();
    if (part != 0) exp_abort = 1;
    check_writes(q ? "wr_quad" : "wr_single");
    chk("wr_no_re", re_cnt, 0);
  endtask

  task automatic do_read(input bit q, input logic [23:0] a, input int nw);
    logic [7:0] e;
    frame_begin();
    send_field(1'b0, q ? 32'h6B : 32'h03, 8);
    send_field(q, {8'h00, a}, 24);
    for (int i = 0; i < NDUM; i++) send_unit(q, 4'($urandom));
    for (int w = 0; w < nw; w++) begin
      e = ref_rd(24'(a + 24'(w)));
      if (q) begin
        recv_unit(1'b1, e[7:4]);
        recv_unit(1'b1, e[3:0]);
      end else begin
        for (int b = 7; b >= 0; b--) recv_unit(1'b0, {3'b000, e[b]});
      end
    end
    frame_end();
    check_writes("rd_no_we");
  endtask

`ifdef QSPI_STATUS_CMD_EN
  task automatic do_status();
    logic [15:0] e;
    e = {exp_abort, exp_badcmd, 6'b0, 8'h00};
    frame_begin();
    send_field(1'b0, 32'h05, 8);
    for (int b = 15; b >= 0; b--) recv_unit(1'b0, {3'b000, e[b]});
    frame_end();
    exp_abort = 0;
    exp_badcmd = 0;
    chk("stat_no_re", re_cnt, 0);
  endtask
`endif

  initial begin
    bit         q;
    logic [23:0] a;
    // Reset state.
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {io_out, io_oe, mem_addr, mem_wdata, mem_we, mem_re, busy}, 0);
    @(negedge clk) rst = 1'b0;
    half();

    // Reset in the middle of the address phase.
    frame_begin();
    send_field(1'b0, 32'h02, 8);
    for (int i = 0; i < 10; i++) send_unit(1'b0, 4'($urandom));
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("reset_mid", {io_out, io_oe, mem_addr, mem_wdata, mem_we, mem_re, busy}, 0);
    @(negedge clk) rst = 1'b0;
    qspi_cs = 1'b1;
    half();
    half();
    chk("reset_no_re", re_cnt, 0);
    chk("reset_no_we", wq.size(), 0);
    exp_abort = 0;
    exp_badcmd = 0;

    // Single-lane write of two words.
    wdat.push_back(8'hA5);
    wdat.push_back(8'h5A);
    do_write(1'b0, 24'h000010, 0);

    // Quad read with known contents.
    ram[24'h20] = 8'h3C; ref_mem[24'h20] = 8'h3C;
    ram[24'h21] = 8'hC3; ref_mem[24'h21] = 8'hC3;
    do_read(1'b1, 24'h000020, 2);

    // Quad write across the top of the address space.
    wdat.push_back(8'($urandom));
    wdat.push_back(8'($urandom));
    do_write(1'b1, 24'hFFFFFF, 0);

    // Write aborted after five data bits.
    do_write(1'b0, 24'h000040, 5);
`ifdef QSPI_STATUS_CMD_EN
    do_status();
`endif

    // Unknown command followed by 32 clocks.
    frame_begin();
    send_field(1'b0, 32'hFF, 8);
    for (int i = 0; i < 32; i++) send_unit(1'b0, 4'($urandom));
    frame_end();
    chk("ign_no_re", re_cnt, 0);
    check_writes("ign_no_we");
    exp_badcmd = 1;
`ifdef QSPI_STATUS_CMD_EN
    do_status();
`else
    frame_begin();
    send_field(1'b0, 32'h05, 8);
    for (int i = 0; i < 16; i++) send_unit(1'b0, 4'($urandom));
    frame_end();
    chk("st05_no_re", re_cnt, 0);
    check_writes("st05_no_we");
`endif

    // Randomised mix of reads and writes, some near the wrap point.
    for (int t = 0; t < 10; t++) begin
      q = 1'($urandom);
      a = ($urandom_range(0, 1) == 1) ? 24'(24'hFFFFFF - 24'($urandom_range(0, 2)))
                                      : 24'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) wdat.push_back(8'($urandom));
        do_write(q, a, 0);
      end else begin
        do_read(q, a, int'($urandom_range(1, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
